// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: response tags, arbitration
// states and parameter legality bounds.
package mem_arb_pkg;

    // Owner of a read response travelling down the response pipe
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_D    = 2'd2
    } resp_tag_e;

    // Which requester wins when both ask in the same cycle
    typedef enum logic {
        D_PRI = 1'b0,
        I_PRI = 1'b1
    } arb_state_e;

    localparam int unsigned MEM_LAT_MIN    = 1;
    localparam int unsigned MEM_LAT_MAX    = 4;
    localparam int unsigned STARVE_MAX_MIN = 1;
    localparam int unsigned STARVE_MAX_MAX = 15;

endpackage

// File: rtl/mem_arb_resp_pipe.sv
// Response tag pipe: tracks which requester owns each in-flight read and
// steers mem_rdata to that requester when the memory returns it. Each
// rdata output holds its last delivered word between responses.
module mem_arb_resp_pipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  resp_tag_e         tag_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o
);

    resp_tag_e         tag_q [MEM_LAT];
    resp_tag_e         tag_out;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    assign tag_out = tag_q[MEM_LAT-1];

    // Shift the issue tag one stage per cycle; reset drops all in-flight reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MEM_LAT; i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            tag_q[0] <= tag_i;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Remember the last word delivered to each requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (tag_out == TAG_IF) if_rdata_q <= mem_rdata_i;
            if (tag_out == TAG_D)  d_rdata_q  <= mem_rdata_i;
        end
    end

    // Steer the returning word to its owner, otherwise present the held word
    always_comb begin
        if_rvalid_o = (tag_out == TAG_IF);
        d_rvalid_o  = (tag_out == TAG_D);
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : if_rdata_q;
        d_rdata_o   = d_rvalid_o  ? mem_rdata_i : d_rdata_q;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port pipelined memory between the fetch (IF) and
// memory-stage (D) requesters. Grants are combinational and issue in the
// request cycle; D normally wins conflicts, and a starvation counter
// temporarily hands priority to IF. Read data is routed back to its owner
// MEM_LAT cycles after the grant.
// Optional build macro: MEM_ARB_PERF_EN adds perf_conflict/perf_if_starve.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_conflict,
    output logic [31:0]       perf_if_starve
`endif
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
        $error("mem_port_arbiter: MEM_LAT out of range");
    end
    if (STARVE_MAX < STARVE_MAX_MIN || STARVE_MAX > STARVE_MAX_MAX) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_MAX out of range");
    end

    arb_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    resp_tag_e  tag_d;

    // Grant selection: a lone requester always wins; conflicts follow state
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (if_req && d_req) begin
            if (state_q == I_PRI) if_gnt = 1'b1;
            else                  d_gnt  = 1'b1;
        end else begin
            if_gnt = if_req;
            d_gnt  = d_req;
        end
    end

    // Memory command and response tag from whichever requester was granted
    always_comb begin
        mem_en    = if_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
        mem_wdata = d_gnt ? d_wdata : '0;
        if_stall  = if_req & ~if_gnt;
        d_stall   = d_req & ~d_gnt;
        if (if_gnt)            tag_d = TAG_IF;
        else if (d_gnt && !d_we) tag_d = TAG_D;
        else                   tag_d = TAG_NONE;
    end

    // Next starvation count and priority state; the boost is decided from the
    // updated count so it lands on the cycle right after the count is reached
    always_comb begin
        cnt_d = cnt_q;
        if (if_gnt) begin
            cnt_d = '0;
        end else if (if_req && (cnt_q < STARVE_LIM)) begin
            cnt_d = cnt_q + 4'd1;
        end
        state_d = state_q;
        case (state_q)
            D_PRI: if (cnt_d == STARVE_LIM) state_d = I_PRI;
            I_PRI: if (if_gnt || !if_req)   state_d = D_PRI;
        endcase
    end

    // Priority FSM and starvation counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= D_PRI;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    mem_arb_resp_pipe #(
        .MEM_LAT (MEM_LAT),
        .DATA_W  (DATA_W)
    ) u_resp_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .tag_i       (tag_d),
        .mem_rdata_i (mem_rdata),
        .if_rvalid_o (if_rvalid),
        .if_rdata_o  (if_rdata),
        .d_rvalid_o  (d_rvalid),
        .d_rdata_o   (d_rdata)
    );

`ifdef MEM_ARB_PERF_EN
    logic [31:0] conflict_q;
    logic [31:0] starve_q;

    // Free-running event counters, wrapping modulo 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= '0;
            starve_q   <= '0;
        end else begin
            if (if_req && d_req)    conflict_q <= conflict_q + 32'd1;
            if (state_q == I_PRI)   starve_q   <= starve_q + 32'd1;
        end
    end

    assign perf_conflict  = conflict_q;
    assign perf_if_starve = starve_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances share one stimulus
// stream and differ only in MEM_LAT (index 0 -> 1, 1 -> 2, 2 -> 3); each has
// its own memory model preloaded with 32'hA500_0000 | address.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NDUT   = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic if_req;
    logic [ADDR_W-1:0] if_addr;
    logic d_req;
    logic d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;

    logic              if_gnt_w    [NDUT];
    logic              if_rvalid_w [NDUT];
    logic [DATA_W-1:0] if_rdata_w  [NDUT];
    logic              if_stall_w  [NDUT];
    logic              d_gnt_w     [NDUT];
    logic              d_rvalid_w  [NDUT];
    logic [DATA_W-1:0] d_rdata_w   [NDUT];
    logic              d_stall_w   [NDUT];
    logic              mem_en_w    [NDUT];
    logic              mem_we_w    [NDUT];
    logic [ADDR_W-1:0] mem_addr_w  [NDUT];
    logic [DATA_W-1:0] mem_wdata_w [NDUT];
    logic [DATA_W-1:0] mem_rdata_w [NDUT];
`ifdef MEM_ARB_PERF_EN
    logic [31:0]       perf_c_w    [NDUT];
    logic [31:0]       perf_s_w    [NDUT];
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned LAT = g + 1;

        mem_port_arbiter #(
            .ADDR_W     (ADDR_W),
            .DATA_W     (DATA_W),
            .MEM_LAT    (LAT),
            .STARVE_MAX (4)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_gnt    (if_gnt_w[g]),
            .if_rvalid (if_rvalid_w[g]),
            .if_rdata  (if_rdata_w[g]),
            .if_stall  (if_stall_w[g]),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_gnt     (d_gnt_w[g]),
            .d_rvalid  (d_rvalid_w[g]),
            .d_rdata   (d_rdata_w[g]),
            .d_stall   (d_stall_w[g]),
            .mem_en    (mem_en_w[g]),
            .mem_we    (mem_we_w[g]),
            .mem_addr  (mem_addr_w[g]),
            .mem_wdata (mem_wdata_w[g]),
            .mem_rdata (mem_rdata_w[g])
`ifdef MEM_ARB_PERF_EN
            ,
            .perf_conflict  (perf_c_w[g]),
            .perf_if_starve (perf_s_w[g])
`endif
        );

        logic [DATA_W-1:0] mem     [512];
        logic [DATA_W-1:0] rd_pipe [LAT];

        initial begin
            for (int i = 0; i < 512; i++) mem[i] = 32'hA500_0000 | 32'(i);
        end

        always @(posedge clk) begin
            if (mem_en_w[g] && mem_we_w[g]) mem[mem_addr_w[g]] <= mem_wdata_w[g];
            rd_pipe[0] <= mem[mem_addr_w[g]];
            for (int k = 1; k < int'(LAT); k++) rd_pipe[k] <= rd_pipe[k-1];
        end

        assign mem_rdata_w[g] = rd_pipe[LAT-1];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
    endtask

    task automatic check_quiet(input int unsigned n, input string tag);
        check_eq($sformatf("%s.if_gnt%0d", tag, n),    32'(if_gnt_w[n]),    32'h0);
        check_eq($sformatf("%s.d_gnt%0d", tag, n),     32'(d_gnt_w[n]),     32'h0);
        check_eq($sformatf("%s.if_rvalid%0d", tag, n), 32'(if_rvalid_w[n]), 32'h0);
        check_eq($sformatf("%s.d_rvalid%0d", tag, n),  32'(d_rvalid_w[n]),  32'h0);
        check_eq($sformatf("%s.if_rdata%0d", tag, n),  if_rdata_w[n],       32'h0);
        check_eq($sformatf("%s.d_rdata%0d", tag, n),   d_rdata_w[n],        32'h0);
        check_eq($sformatf("%s.stalls%0d", tag, n),    32'({if_stall_w[n], d_stall_w[n]}), 32'h0);
        check_eq($sformatf("%s.mem_en%0d", tag, n),    32'({mem_en_w[n], mem_we_w[n]}), 32'h0);
        check_eq($sformatf("%s.mem_addr%0d", tag, n),  32'(mem_addr_w[n]),  32'h0);
        check_eq($sformatf("%s.mem_wdata%0d", tag, n), mem_wdata_w[n],      32'h0);
    endtask

    initial begin
        // bit i set = D expected to win cycle i of a held conflict
        logic [5:0] starve_d_win;
        logic [6:0] pipe_if_rv;
        logic [6:0] pipe_d_rv;
        logic [4:0] post_rst_d_win;
        starve_d_win   = 6'b101111;
        pipe_if_rv     = 7'b0101000;
        pipe_d_rv      = 7'b1010000;
        post_rst_d_win = 5'b01111;

        rst_n = 1'b0;
        idle();

        // Reset state
        cyc();
        cyc();
        for (int unsigned n = 0; n < NDUT; n++) check_quiet(n, "reset");
        rst_n = 1'b1;
        cyc();
        cyc();

        // IF-only read of 9'h014
        if_req  = 1'b1;
        if_addr = 9'h014;
        #1;
        check_eq("if_only.if_gnt",   32'(if_gnt_w[0]),   32'h1);
        check_eq("if_only.mem_en",   32'(mem_en_w[0]),   32'h1);
        check_eq("if_only.mem_we",   32'(mem_we_w[0]),   32'h0);
        check_eq("if_only.mem_addr", 32'(mem_addr_w[0]), 32'h014);
        check_eq("if_only.if_stall", 32'(if_stall_w[0]), 32'h0);
        check_eq("if_only.d_gnt",    32'(d_gnt_w[0]),    32'h0);
        cyc();
        idle();
        #1;
        check_eq("if_only.if_rvalid", 32'(if_rvalid_w[0]), 32'h1);
        check_eq("if_only.if_rdata",  if_rdata_w[0],       32'hA500_0014);
        check_eq("if_only.d_rvalid",  32'(d_rvalid_w[0]),  32'h0);
        check_eq("if_only.d_rdata",   d_rdata_w[0],        32'h0);
        cyc();
        check_eq("if_only.rvalid_drop", 32'(if_rvalid_w[0]), 32'h0);
        check_eq("if_only.rdata_hold",  if_rdata_w[0],       32'hA500_0014);
        cyc();

        // Conflict in D_PRI: D read of 9'h020 wins, IF stalls
        if_req  = 1'b1;
        if_addr = 9'h030;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 9'h020;
        #1;
        check_eq("conflict.d_gnt",    32'(d_gnt_w[0]),    32'h1);
        check_eq("conflict.if_gnt",   32'(if_gnt_w[0]),   32'h0);
        check_eq("conflict.if_stall", 32'(if_stall_w[0]), 32'h1);
        check_eq("conflict.d_stall",  32'(d_stall_w[0]),  32'h0);
        check_eq("conflict.mem_addr", 32'(mem_addr_w[0]), 32'h020);
        cyc();
        idle();
        #1;
        check_eq("conflict.d_rvalid_l1", 32'(d_rvalid_w[0]), 32'h1);
        check_eq("conflict.d_rdata_l1",  d_rdata_w[0],       32'hA500_0020);
        check_eq("conflict.if_rvalid_l1", 32'(if_rvalid_w[0]), 32'h0);
        cyc();
        check_eq("conflict.d_rvalid_l3_early", 32'(d_rvalid_w[2]), 32'h0);
        cyc();
        check_eq("conflict.d_rvalid_l3", 32'(d_rvalid_w[2]), 32'h1);
        check_eq("conflict.d_rdata_l3",  d_rdata_w[2],       32'hA500_0020);
        // Lone IF grant clears the starvation count left by the conflict
        cyc();
        if_req  = 1'b1;
        if_addr = 9'h000;
        cyc();
        idle();
        for (int i = 0; i < 4; i++) cyc();

        // Starvation: both held six cycles, IF boosted on cycle 4
        for (int i = 0; i < 6; i++) begin
            if_req  = 1'b1;
            if_addr = 9'h040;
            d_req   = 1'b1;
            d_we    = 1'b0;
            d_addr  = 9'h050;
            #1;
            check_eq($sformatf("starve.d_gnt[%0d]", i),  32'(d_gnt_w[0]),  32'(starve_d_win[i]));
            check_eq($sformatf("starve.if_gnt[%0d]", i), 32'(if_gnt_w[0]), 32'(!starve_d_win[i]));
            if (!starve_d_win[i])
                check_eq("starve.mem_addr_if", 32'(mem_addr_w[0]), 32'h040);
            cyc();
        end
        idle();
        for (int i = 0; i < 5; i++) cyc();

        // D write of 32'hDEADBEEF to 9'h003
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 9'h003;
        d_wdata = 32'hDEAD_BEEF;
        #1;
        check_eq("write.d_gnt",     32'(d_gnt_w[0]),    32'h1);
        check_eq("write.mem_en",    32'(mem_en_w[0]),   32'h1);
        check_eq("write.mem_we",    32'(mem_we_w[0]),   32'h1);
        check_eq("write.mem_addr",  32'(mem_addr_w[0]), 32'h003);
        check_eq("write.mem_wdata", mem_wdata_w[0],     32'hDEAD_BEEF);
        cyc();
        idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            for (int unsigned n = 0; n < NDUT; n++)
                check_eq($sformatf("write.no_d_rvalid%0d[%0d]", n, i), 32'(d_rvalid_w[n]), 32'h0);
            cyc();
        end
        // Read the written word back over the IF port
        if_req  = 1'b1;
        if_addr = 9'h003;
        cyc();
        idle();
        #1;
        check_eq("write.readback_rvalid", 32'(if_rvalid_w[0]), 32'h1);
        check_eq("write.readback_rdata",  if_rdata_w[0],       32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) cyc();

        // Pipelined alternating IF/D reads, checked on the MEM_LAT = 3 instance
        for (int i = 0; i < 7; i++) begin
            idle();
            if (i < 4) begin
                if (i % 2 == 0) begin
                    if_req  = 1'b1;
                    if_addr = 9'h100 + 9'(i);
                end else begin
                    d_req  = 1'b1;
                    d_addr = 9'h100 + 9'(i);
                end
            end
            #1;
            if (i < 4) begin
                check_eq($sformatf("pipe.mem_addr[%0d]", i), 32'(mem_addr_w[2]), 32'h100 + 32'(i));
                check_eq($sformatf("pipe.gnt[%0d]", i), 32'({if_gnt_w[2], d_gnt_w[2]}),
                         (i % 2 == 0) ? 32'h2 : 32'h1);
            end
            check_eq($sformatf("pipe.if_rvalid[%0d]", i), 32'(if_rvalid_w[2]), 32'(pipe_if_rv[i]));
            check_eq($sformatf("pipe.d_rvalid[%0d]", i),  32'(d_rvalid_w[2]),  32'(pipe_d_rv[i]));
            if (pipe_if_rv[i])
                check_eq($sformatf("pipe.if_rdata[%0d]", i), if_rdata_w[2], 32'hA500_0100 + 32'(i - 3));
            if (pipe_d_rv[i])
                check_eq($sformatf("pipe.d_rdata[%0d]", i), d_rdata_w[2], 32'hA500_0100 + 32'(i - 3));
            cyc();
        end
        idle();
        for (int i = 0; i < 3; i++) cyc();

        // Reset mid-flight on the MEM_LAT = 2 instance, with starvation count at 3
        for (int i = 0; i < 3; i++) begin
            if_req  = 1'b1;
            if_addr = 9'h010;
            d_req   = 1'b1;
            d_addr  = 9'h011;
            cyc();
        end
        idle();
        d_req  = 1'b1;
        d_addr = 9'h021;
        #1;
        check_eq("rst.d_gnt", 32'(d_gnt_w[1]), 32'h1);
        cyc();
        idle();
        rst_n = 1'b0;
        #1;
        check_quiet(1, "rst_c1");
        cyc();
        check_quiet(1, "rst_c2");
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("rst.no_d_rvalid[%0d]", i), 32'(d_rvalid_w[1]), 32'h0);
            check_eq($sformatf("rst.d_rdata[%0d]", i),     d_rdata_w[1],       32'h0);
            cyc();
        end
        // Count and state restart from zero / D_PRI: D wins four conflicts first
        for (int i = 0; i < 5; i++) begin
            if_req  = 1'b1;
            if_addr = 9'h060;
            d_req   = 1'b1;
            d_addr  = 9'h061;
            #1;
            check_eq($sformatf("post_rst.d_gnt[%0d]", i),  32'(d_gnt_w[1]),  32'(post_rst_d_win[i]));
            check_eq($sformatf("post_rst.if_gnt[%0d]", i), 32'(if_gnt_w[1]), 32'(!post_rst_d_win[i]));
            cyc();
        end
        idle();
        for (int i = 0; i < 4; i++) cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
